// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: branch/opcode constants and the control bundle
// that travels from the control unit through ID/EX.
package mips_pkg;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_JMP  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_BEZ  = 2'd3;

  localparam logic [5:0] OP_NOP = 6'd0;
  localparam logic [5:0] OP_LD  = 6'd36;
  localparam logic [5:0] OP_ST  = 6'd37;

  typedef struct packed {
    logic [3:0] exec_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       is_imm;
    logic [1:0] branch_type;
  } ctrl_t;

  // Zeroes the control bundle when the slot does not hold a real instruction.
  function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic en);
    ctrl_gate = en ? c : '0;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX bus: decoded instruction fields in, registered EX fields out.
// Ports: master drives id_* / reads ex_*; slave (the stage) the reverse.
interface id_ex_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);

  logic                  id_valid;
  logic [5:0]            id_opcode;
  logic [3:0]            id_exec_cmd;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_wb_en;
  logic                  id_is_imm;
  logic [1:0]            id_branch_type;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic [REG_ADDR_W-1:0] id_dest;
  logic [DATA_W-1:0]     id_val1;
  logic [DATA_W-1:0]     id_val2;
  logic [DATA_W-1:0]     id_imm;
  logic [DATA_W-1:0]     id_pc;

  logic                  ex_valid;
  logic [3:0]            ex_exec_cmd;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_wb_en;
  logic                  ex_is_imm;
  logic [1:0]            ex_branch_type;
  logic [REG_ADDR_W-1:0] ex_src1;
  logic [REG_ADDR_W-1:0] ex_src2;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic [DATA_W-1:0]     ex_val1;
  logic [DATA_W-1:0]     ex_val2;
  logic [DATA_W-1:0]     ex_imm;
  logic [DATA_W-1:0]     ex_pc;

  modport master (
    output id_valid, id_opcode, id_exec_cmd,
    output id_mem_read, id_mem_write,
    output id_wb_en, id_is_imm, id_branch_type,
    output id_src1, id_src2, id_dest,
    output id_val1, id_val2, id_imm, id_pc,
    input  ex_valid, ex_exec_cmd,
    input  ex_mem_read, ex_mem_write,
    input  ex_wb_en, ex_is_imm, ex_branch_type,
    input  ex_src1, ex_src2, ex_dest,
    input  ex_val1, ex_val2, ex_imm, ex_pc
  );

  modport slave (
    input  id_valid, id_opcode, id_exec_cmd,
    input  id_mem_read, id_mem_write,
    input  id_wb_en, id_is_imm, id_branch_type,
    input  id_src1, id_src2, id_dest,
    input  id_val1, id_val2, id_imm, id_pc,
    output ex_valid, ex_exec_cmd,
    output ex_mem_read, ex_mem_write,
    output ex_wb_en, ex_is_imm, ex_branch_type,
    output ex_src1, ex_src2, ex_dest,
    output ex_val1, ex_val2, ex_imm, ex_pc
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detector (combinational). Inputs: ID operand usage info and
// the EX load's dest; output: o_hazard_stall, masked while a flush is in flight.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_id_valid,
  input  logic [5:0]            i_id_opcode,
  input  logic                  i_id_is_imm,
  input  logic                  i_id_mem_write,
  input  logic [1:0]            i_id_branch_type,
  input  logic [REG_ADDR_W-1:0] i_id_src1,
  input  logic [REG_ADDR_W-1:0] i_id_src2,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_dest,
  input  logic                  i_flush,
  output logic                  o_hazard_stall
);

  logic w_real;
  logic w_src1_used;
  logic w_src2_used;
  logic w_ld_live;
  logic w_hit1;
  logic w_hit2;

  assign w_real = i_id_valid && (i_id_opcode != OP_NOP);

  // JMP carries only an immediate target.
  assign w_src1_used = w_real && (i_id_branch_type != BR_JMP);

  // Stores and BNE read src2 even though is_imm is set.
  assign w_src2_used = w_real
    && (!i_id_is_imm || i_id_mem_write
        || (i_id_branch_type == BR_BNE));

  // R0 is hardwired zero, never a real producer.
  assign w_ld_live = i_ex_valid && i_ex_mem_read
    && (i_ex_dest != '0);

  assign w_hit1 = w_src1_used && (i_id_src1 == i_ex_dest);
  assign w_hit2 = w_src2_used && (i_id_src2 == i_ex_dest);

  assign o_hazard_stall = !i_flush && w_ld_live
    && (w_hit1 || w_hit2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush, freeze and a saturating
// bubble counter. Ports: clk, rst, freeze, flush, bus, hazard_stall, bubble_count.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  id_ex_stage_if.slave     bus,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic                  r_valid;
  ctrl_t                 r_ctrl;
  logic [REG_ADDR_W-1:0] r_src1;
  logic [REG_ADDR_W-1:0] r_src2;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0]     r_val1;
  logic [DATA_W-1:0]     r_val2;
  logic [DATA_W-1:0]     r_imm;
  logic [DATA_W-1:0]     r_pc;
  logic [CNT_W-1:0]      r_bubbles;

  ctrl_t w_id_ctrl;
  logic  w_stall;

  assign w_id_ctrl = {
    bus.id_exec_cmd,
    bus.id_mem_read,
    bus.id_mem_write,
    bus.id_wb_en,
    bus.id_is_imm,
    bus.id_branch_type
  };

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .i_id_valid       (bus.id_valid),
    .i_id_opcode      (bus.id_opcode),
    .i_id_is_imm      (bus.id_is_imm),
    .i_id_mem_write   (bus.id_mem_write),
    .i_id_branch_type (bus.id_branch_type),
    .i_id_src1        (bus.id_src1),
    .i_id_src2        (bus.id_src2),
    .i_ex_valid       (r_valid),
    .i_ex_mem_read    (r_ctrl.mem_read),
    .i_ex_dest        (r_dest),
    .i_flush          (flush),
    .o_hazard_stall   (w_stall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_dest    <= '0;
      r_val1    <= '0;
      r_val2    <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_bubbles <= '0;
    end else if (!freeze) begin
      if (flush || w_stall) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        r_src1  <= '0;
        r_src2  <= '0;
        r_dest  <= '0;
        r_val1  <= '0;
        r_val2  <= '0;
        r_imm   <= '0;
        r_pc    <= '0;
        // w_stall is already 0 under flush, so only
        // load-use bubbles reach the counter.
        if (w_stall && (r_bubbles != CNT_MAX))
          r_bubbles <= r_bubbles + CNT_ONE;
      end else begin
        r_valid <= bus.id_valid;
        r_ctrl  <= ctrl_gate(w_id_ctrl, bus.id_valid);
        r_src1  <= bus.id_src1;
        r_src2  <= bus.id_src2;
        r_dest  <= bus.id_dest;
        r_val1  <= bus.id_val1;
        r_val2  <= bus.id_val2;
        r_imm   <= bus.id_imm;
        r_pc    <= bus.id_pc;
      end
    end
  end

  assign bus.ex_valid       = r_valid;
  assign bus.ex_exec_cmd    = r_ctrl.exec_cmd;
  assign bus.ex_mem_read    = r_ctrl.mem_read;
  assign bus.ex_mem_write   = r_ctrl.mem_write;
  assign bus.ex_wb_en       = r_ctrl.wb_en;
  assign bus.ex_is_imm      = r_ctrl.is_imm;
  assign bus.ex_branch_type = r_ctrl.branch_type;
  assign bus.ex_src1        = r_src1;
  assign bus.ex_src2        = r_src2;
  assign bus.ex_dest        = r_dest;
  assign bus.ex_val1        = r_val1;
  assign bus.ex_val2        = r_val2;
  assign bus.ex_imm         = r_imm;
  assign bus.ex_pc          = r_pc;

  assign hazard_stall = w_stall;
  assign bubble_count = r_bubbles;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed test-plan scenarios plus random
// traffic against a field-level reference model of the EX slot.
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    bit        v;
    bit [5:0]  op;
    bit [3:0]  cmd;
    bit        mr;
    bit        mw;
    bit        wb;
    bit        imf;
    bit [1:0]  bt;
    bit [4:0]  s1;
    bit [4:0]  s2;
    bit [4:0]  d;
    bit [31:0] v1;
    bit [31:0] v2;
    bit [31:0] imm;
    bit [31:0] pc;
  } ins_t;

  typedef struct {
    ins_t ex;
    bit   hz;
    int   cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             freeze;
  logic             flush;
  logic             hazard_stall;
  logic [CNT_W-1:0] bubble_count;

  id_ex_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  id_ex_stage #(
    .DATA_W     (32),
    .REG_ADDR_W (5),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .flush        (flush),
    .bus          (bus),
    .hazard_stall (hazard_stall),
    .bubble_count (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  ins_t cur;
  int   cnt;
  int   compared;
  int   mismatched;

  function automatic ins_t bubble();
    ins_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic ins_t mk(
    bit [5:0] op, bit [3:0] cmd, bit mr, bit mw,
    bit wb, bit imf, bit [1:0] bt,
    bit [4:0] s1, bit [4:0] s2, bit [4:0] d,
    bit [31:0] imm);
    ins_t x;
    x.v = 1'b1; x.op = op; x.cmd = cmd;
    x.mr = mr; x.mw = mw; x.wb = wb; x.imf = imf;
    x.bt = bt; x.s1 = s1; x.s2 = s2; x.d = d;
    x.imm = imm;
    x.v1 = $urandom; x.v2 = $urandom; x.pc = $urandom;
    return x;
  endfunction

  function automatic ins_t rnd();
    ins_t x;
    int   k;
    x = '{default: 0};
    k = $urandom_range(0, 4);
    x.v = ($urandom_range(0, 7) != 0);
    x.cmd = 4'($urandom_range(0, 15));
    case (k)
      0: x.op = 6'd0;
      1: begin x.op = OP_LD; x.mr = 1; x.wb = 1; x.imf = 1; end
      2: begin x.op = OP_ST; x.mw = 1; x.imf = 1; end
      3: begin x.op = 6'd32; x.wb = 1; x.imf = 1; end
      default: begin
        x.op = 6'd1;
        x.wb = 1'($urandom_range(0, 1));
        x.imf = 1'($urandom_range(0, 1));
        x.bt = 2'($urandom_range(0, 3));
      end
    endcase
    x.s1 = 5'($urandom_range(0, 3));
    x.s2 = 5'($urandom_range(0, 3));
    x.d = 5'($urandom_range(0, 3));
    x.v1 = $urandom; x.v2 = $urandom;
    x.imm = $urandom; x.pc = $urandom;
    return x;
  endfunction

  // Reads of a register by the ID instruction, from the ISA usage rules.
  function automatic bit hazard(ins_t id, bit fl);
    bit real_i;
    bit u1;
    bit u2;
    real_i = id.v && (id.op != 0);
    u1 = real_i && (id.bt != 1);
    u2 = real_i && (!id.imf || id.mw || id.bt == 2);
    if (fl) return 1'b0;
    if (!(cur.v && cur.mr && cur.d != 0)) return 1'b0;
    return (u1 && id.s1 == cur.d) || (u2 && id.s2 == cur.d);
  endfunction

  task automatic drive(ins_t id);
    bus.id_valid       = id.v;
    bus.id_opcode      = id.op;
    bus.id_exec_cmd    = id.cmd;
    bus.id_mem_read    = id.mr;
    bus.id_mem_write   = id.mw;
    bus.id_wb_en       = id.wb;
    bus.id_is_imm      = id.imf;
    bus.id_branch_type = id.bt;
    bus.id_src1        = id.s1;
    bus.id_src2        = id.s2;
    bus.id_dest        = id.d;
    bus.id_val1        = id.v1;
    bus.id_val2        = id.v2;
    bus.id_imm         = id.imm;
    bus.id_pc          = id.pc;
  endtask

  task automatic apply(ins_t id, bit fz, bit fl);
    exp_t e;
    bit   h;
    drive(id);
    freeze = fz;
    flush = fl;
    h = hazard(id, fl);
    e.ex = cur; e.hz = h; e.cnt = cnt;
    q.push_back(e);
    if (!fz) begin
      if (fl) begin
        cur = bubble();
      end else if (h) begin
        cur = bubble();
        if (cnt < CMAX) cnt++;
      end else begin
        cur = id;
        if (!id.v) begin
          cur.cmd = 0; cur.mr = 0; cur.mw = 0;
          cur.wb = 0; cur.imf = 0; cur.bt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    rst = 1'b1;
    cur = bubble();
    cnt = 0;
    e.ex = cur; e.hz = 1'b0; e.cnt = 0;
    q.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check(string name, logic [127:0] act,
                       logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h @%0t",
               name, act, req, $time);
    end
  endtask

  // Monitor: one expected record per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ctrl",
          128'({bus.ex_valid, bus.ex_exec_cmd,
                bus.ex_mem_read, bus.ex_mem_write,
                bus.ex_wb_en, bus.ex_is_imm,
                bus.ex_branch_type}),
          128'({e.ex.v, e.ex.cmd, e.ex.mr, e.ex.mw,
                e.ex.wb, e.ex.imf, e.ex.bt}));
        if (e.ex.v) begin
          check("regs",
            128'({bus.ex_src1, bus.ex_src2, bus.ex_dest}),
            128'({e.ex.s1, e.ex.s2, e.ex.d}));
          check("data",
            {bus.ex_val1, bus.ex_val2, bus.ex_imm, bus.ex_pc},
            {e.ex.v1, e.ex.v2, e.ex.imm, e.ex.pc});
        end
        check("hazard_stall", 128'(hazard_stall), 128'(e.hz));
        check("bubble_count", 128'(bubble_count),
              128'(e.cnt));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t ld7;
    ins_t add7;
    ins_t x;
    compared = 0;
    mismatched = 0;
    cur = bubble();
    cnt = 0;
    rst = 1'b1;
    freeze = 1'b0;
    flush = 1'b0;
    drive(bubble());
    @(posedge clk);
    #1;
    do_reset();

    ld7  = mk(OP_LD, 4'd0, 1, 0, 1, 1, BR_NONE, 5'd1, 5'd0, 5'd7, 32'd8);
    add7 = mk(6'd1, 4'd1, 0, 0, 1, 0, BR_NONE, 5'd2, 5'd7, 5'd8, 32'd0);

    // Normal flow: ADDI r4 = r3 + 5.
    apply(mk(6'd32, 4'd0, 0, 0, 1, 1, BR_NONE, 5'd3, 5'd0, 5'd4, 32'd5), 0, 0);
    // Load-use: one bubble, then the ADD enters EX.
    apply(ld7, 0, 0);
    apply(add7, 0, 0);
    apply(add7, 0, 0);
    apply(bubble(), 0, 0);
    // LD to R0 then R0 reader: no stall.
    apply(mk(OP_LD, 4'd0, 1, 0, 1, 1, BR_NONE, 5'd1, 5'd0, 5'd0, 32'd4), 0, 0);
    apply(mk(6'd1, 4'd1, 0, 0, 1, 0, BR_NONE, 5'd0, 5'd0, 5'd9, 32'd0), 0, 0);
    // Immediate form does not read src2.
    apply(ld7, 0, 0);
    apply(mk(6'd32, 4'd0, 0, 0, 1, 1, BR_NONE, 5'd1, 5'd7, 5'd9, 32'd3), 0, 0);
    // Store reads src2.
    x = mk(OP_ST, 4'd0, 0, 1, 0, 1, BR_NONE, 5'd1, 5'd7, 5'd0, 32'd12);
    apply(ld7, 0, 0);
    apply(x, 0, 0);
    apply(x, 0, 0);
    // Flush wins over a simultaneous load-use hazard.
    apply(ld7, 0, 0);
    apply(add7, 0, 1);
    apply(bubble(), 0, 0);
    // Freeze for three cycles with changing ID, including a live hazard.
    apply(ld7, 0, 0);
    apply(add7, 1, 0);
    apply(rnd(), 1, 0);
    apply(rnd(), 1, 0);
    apply(add7, 0, 0);
    apply(add7, 0, 0);
    // Reset while a hazard is pending.
    apply(ld7, 0, 0);
    drive(add7);
    do_reset();
    // Saturation of the bubble counter.
    for (int i = 0; i < CMAX + 5; i++) begin
      apply(ld7, 0, 0);
      apply(add7, 0, 0);
      apply(add7, 0, 0);
    end
    do_reset();
    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      apply(rnd(), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0));
    end
    apply(bubble(), 0, 0);
    repeat (2) @(posedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d records left, required 0",
               q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (control unit plus register file) and execute in the 5-stage MIPS core.
- Captures the control unit's outputs, the operand values and the register addresses.
- Detects load-use hazards, stalling IF/ID and inserting a bubble.
- Honours branch flush and global freeze, and keeps a saturating bubble counter for debug.

Parameters:
DATA_W, 32, operand/immediate/PC width
REG_ADDR_W, 5, register index width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
freeze  in  1  global hold (memory wait); all state held
flush  in  1  branch taken in EX; squash instruction entering EX
id_valid  in  1  ID holds a real instruction
id_opcode  in  6  opcode of ID instruction
id_exec_cmd  in  4  ALU command from control unit
id_mem_read, id_mem_write, id_wb_en, id_is_imm  in  1 each  control unit outputs
id_branch_type  in  2  0 none, 1 JMP, 2 BNE, 3 BEZ
id_src1, id_src2, id_dest  in  REG_ADDR_W each  register indices
id_val1, id_val2, id_imm, id_pc  in  DATA_W each  operands, sign-extended immediate, PC+4
ex_valid  out  1  EX holds a real instruction
ex_exec_cmd  out  4
ex_mem_read, ex_mem_write, ex_wb_en, ex_is_imm  out  1 each
ex_branch_type  out  2
ex_src1, ex_src2, ex_dest  out  REG_ADDR_W each
ex_val1, ex_val2, ex_imm, ex_pc  out  DATA_W each
hazard_stall  out  1  combinational; hold PC and IF/ID this cycle
bubble_count  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset is async and active-high. It clears every registered output to 0, including ex_valid and bubble_count, which makes EX a bubble.
- Bubble: ex_valid=0 and all ex_* control outputs 0. Data fields are don't-care and are driven to 0.
- src1_used = id_valid and id_opcode!=0 and id_branch_type!=1.
- src2_used = id_valid and id_opcode!=0 and (id_is_imm=0 or id_mem_write or id_branch_type==2).
- hazard_stall = ex_valid and ex_mem_read and ex_dest!=0 and ((src1_used and id_src1==ex_dest) or (src2_used and id_src2==ex_dest)).
- hazard_stall is masked to 0 when flush=1, because the ID instruction is being squashed anyway.
- Per-edge priority, highest first:
  1. freeze=1: all registers hold and the counter holds. hazard_stall still evaluates combinationally.
  2. flush=1: load a bubble. The counter does not increment, since a flush is not a hazard bubble.
  3. hazard_stall=1: load a bubble and increment bubble_count.
  4. Otherwise: load the ID fields. ex_valid is set to id_valid. If id_valid=0, the controls are forced to 0.
- Latency: one cycle, ID to EX.
- A load-use dependency costs exactly one bubble. After the bubble, ex_mem_read=0, so hazard_stall deasserts automatically.
- bubble_count stops at 2^CNT_W-1 and never wraps.
- Register 0 is never a hazard source.
- Reset asserted mid-stall clears everything immediately. There is no pending state.

Decomposition:
- Shared package mips_pkg holds:
  - branch-type constants BR_NONE=0, BR_JMP=1, BR_BNE=2, BR_BEZ=3;
  - opcode constants OP_NOP=0, OP_LD=36, OP_ST=37;
  - a packed ctrl_t struct {exec_cmd, mem_read, mem_write, wb_en, is_imm, branch_type}.
- One sub-module, hazard_detect: purely combinational, computes src1_used, src2_used and hazard_stall. It is instantiated once; the register bank stays in id_ex_stage.

Test Plan:
- Reset during traffic: assert rst with EX loaded -> all outputs 0 immediately, bubble_count=0.
- Normal flow: id ADDI (opcode 32, src1=3, dest=4, imm=5) -> next cycle ex_valid=1, ex_exec_cmd=0, ex_wb_en=1, ex_is_imm=1, ex_dest=4, ex_imm=5.
- Load-use: EX=LD dest=7, ID=ADD src2=7 -> hazard_stall=1, next EX bubble, bubble_count=1. The cycle after, ADD enters EX and hazard_stall=0.
- No false hazards:
  - LD dest=0 followed by a reader of R0 -> no stall.
  - LD dest=7 followed by ADDI src2=7 (immediate, src2 unused) -> no stall.
  - ST src2=7 -> stall.
- Flush priority: flush=1 in the same cycle as a load-use hazard -> bubble loaded, hazard_stall=0, bubble_count unchanged.
- Freeze: freeze=1 for 3 cycles with changing ID inputs -> ex_* outputs and bubble_count constant. Saturation check: preload or force the counter to 0xFFFF, create a hazard -> stays 0xFFFF.
